// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ID/EX bus layout, ALU and mult/div op codes.
package ex_stage_pkg;

  localparam int unsigned MdCyclesDefault = 32;

  localparam int unsigned IdexW        = 93;
  localparam int unsigned IdexAOff     = 0;
  localparam int unsigned IdexBOff     = 32;
  localparam int unsigned IdexWeBit    = 64;
  localparam int unsigned IdexAluOff   = 65;
  localparam int unsigned IdexDstOff   = 69;
  localparam int unsigned IdexCinBit   = 74;
  localparam int unsigned IdexMdOff    = 75;
  localparam int unsigned IdexValidBit = 78;

  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluAdd = 4'b0010,
    AluXor = 4'b0011,
    AluSub = 4'b0110,
    AluSlt = 4'b0111,
    AluNor = 4'b1100
  } alu_ctl_e;

  typedef enum logic [2:0] {
    MdNone  = 3'b000,
    MdMult  = 3'b001,
    MdMultu = 3'b010,
    MdDiv   = 3'b011,
    MdDivu  = 3'b100,
    MdMfhi  = 3'b101,
    MdMflo  = 3'b110,
    MdRsvd  = 3'b111
  } md_op_e;

  function automatic logic md_is_start(md_op_e op);
    return op inside {MdMult, MdMultu, MdDiv, MdDivu};
  endfunction

endpackage

// File: rtl/ex_stage_muldiv_iter.sv
// Iterative radix-2 unit: shift-add multiply and restoring divide on magnitudes,
// sign fix-up on the final iteration. Owns the HI/LO registers.
module ex_stage_muldiv_iter
  import ex_stage_pkg::*;
#(
  parameter int unsigned MdCycles = MdCyclesDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned CntW = $clog2(MdCycles);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [63:0]     p_q, p_d;
  logic [31:0]     opnd_q, a_raw_q, hi_q, lo_q;
  logic            is_div_q, neg_prod_q, neg_rem_q, div0_q;

  logic        st_signed, st_div, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_r, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, hi_fin, lo_fin;
  logic        last;

  // Operand preparation at start
  always_comb begin
    st_signed = (op_i == MdMult) || (op_i == MdDiv);
    st_div    = (op_i == MdDiv) || (op_i == MdDivu);
    a_neg     = st_signed & a_i[31];
    b_neg     = st_signed & b_i[31];
    a_mag     = a_neg ? (~a_i + 32'd1) : a_i;
    b_mag     = b_neg ? (~b_i + 32'd1) : b_i;
  end

  // One iteration; p_q holds {acc, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_r    = {p_q[63:32], p_q[31]};
    div_diff = div_r - {1'b0, opnd_q};
    if (is_div_q) begin
      if (div_r >= {1'b0, opnd_q}) p_d = {div_diff[31:0], p_q[30:0], 1'b1};
      else                         p_d = {div_r[31:0], p_q[30:0], 1'b0};
    end else begin
      p_d = {mul_sum, p_q[31:1]};
    end

    prod_fix = neg_prod_q ? (~p_d + 64'd1) : p_d;
    quo_fix  = neg_prod_q ? (~p_d[31:0] + 32'd1) : p_d[31:0];
    rem_fix  = neg_rem_q ? (~p_d[63:32] + 32'd1) : p_d[63:32];
    if (!is_div_q) begin
      hi_fin = prod_fix[63:32];
      lo_fin = prod_fix[31:0];
    end else if (div0_q) begin
      hi_fin = a_raw_q;
      lo_fin = 32'hFFFF_FFFF;
    end else begin
      hi_fin = rem_fix;
      lo_fin = quo_fix;
    end
  end

  assign last = (cnt_q == CntW'(MdCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      p_q        <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StBusy;
            cnt_q      <= '0;
            is_div_q   <= st_div;
            opnd_q     <= st_div ? b_mag : a_mag;
            p_q        <= {32'd0, st_div ? a_mag : b_mag};
            a_raw_q    <= a_i;
            neg_prod_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div0_q     <= st_div & (b_i == 32'd0);
          end
        end
        StBusy: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + CntW'(1);
          if (last) begin
            hi_q    <= hi_fin;
            lo_q    <= lo_fin;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q == StBusy);
  assign done_o = busy_o & last;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, HI/LO-hazard stall and EX/MEM output muxing
// around the iterative mult/div unit.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned MdCycles = MdCyclesDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IdexW-1:0] idex_bus,
  output logic [31:0]      ex_result,
  output logic             ex_we,
  output logic [4:0]       ex_dst,
  output logic             ex_valid,
  output logic             stall,
  output logic             md_busy
);

  logic [31:0] op_a, op_b, alu_result, hi, lo;
  logic        wr_en, cin, valid, is_start, is_mf, md_start, md_done;
  logic [4:0]  dst;
  alu_ctl_e    alu_ctl;
  md_op_e      md_op;
  logic        unused_bits;

  assign op_a    = idex_bus[IdexAOff +: 32];
  assign op_b    = idex_bus[IdexBOff +: 32];
  assign wr_en   = idex_bus[IdexWeBit];
  assign alu_ctl = alu_ctl_e'(idex_bus[IdexAluOff +: 4]);
  assign dst     = idex_bus[IdexDstOff +: 5];
  assign cin     = idex_bus[IdexCinBit];
  assign md_op   = md_op_e'(idex_bus[IdexMdOff +: 3]);
  assign valid   = idex_bus[IdexValidBit];

  assign unused_bits = ^{idex_bus[IdexW-1:IdexValidBit+1], md_done};

  assign is_start = md_is_start(md_op);
  assign is_mf    = (md_op == MdMfhi) || (md_op == MdMflo);
  // Only ops touching the unit or HI/LO wait; plain ALU ops overlap a busy unit
  assign stall    = valid & (is_start | is_mf) & md_busy;
  assign md_start = valid & is_start & ~md_busy;

  always_comb begin
    case (alu_ctl)
      AluAnd:  alu_result = op_a & op_b;
      AluOr:   alu_result = op_a | op_b;
      AluAdd:  alu_result = op_a + op_b + {31'd0, cin};
      AluXor:  alu_result = op_a ^ op_b;
      AluSub:  alu_result = op_a - op_b;
      AluSlt:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      AluNor:  alu_result = ~(op_a | op_b);
      default: alu_result = 32'd0;
    endcase
  end

  always_comb begin
    ex_valid = valid & ~stall;
    ex_we    = wr_en & valid & ~stall & ~is_start;
    ex_dst   = dst;
    case (md_op)
      MdMfhi:  ex_result = hi;
      MdMflo:  ex_result = lo;
      default: ex_result = alu_result;
    endcase
  end

  ex_stage_muldiv_iter #(
    .MdCycles(MdCycles)
  ) u_muldiv (
    .clk_i  (clk),
    .rst_ni (rst),
    .start_i(md_start),
    .op_i   (md_op),
    .a_i    (op_a),
    .b_i    (op_b),
    .busy_o (md_busy),
    .done_o (md_done),
    .hi_o   (hi),
    .lo_o   (lo)
  );

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver queues expected EX/MEM outputs,
// a monitor pops and compares on every valid output cycle.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [92:0] idex_bus = '0;
  logic [31:0] ex_result;
  logic        ex_we, ex_valid, stall, md_busy;
  logic [4:0]  ex_dst;

  typedef struct {
    logic [31:0] res;
    bit          chk_res;
    logic        we;
    logic [4:0]  dst;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   bad_stall_cycles = 0;

  ex_stage dut (
    .clk      (clk),
    .rst      (rst),
    .idex_bus (idex_bus),
    .ex_result(ex_result),
    .ex_we    (ex_we),
    .ex_dst   (ex_dst),
    .ex_valid (ex_valid),
    .stall    (stall),
    .md_busy  (md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [92:0] mk(input logic [31:0] a, input logic [31:0] b, input logic we,
                                     input logic [3:0] alu, input logic [4:0] dst,
                                     input logic cin, input logic [2:0] md);
    return {14'd0, 1'b1, md, cin, dst, alu, we, b, a};
  endfunction

  // Present one bus word at the start of a cycle and hold it until it is not stalled
  task automatic issue(input logic [92:0] bus, input bit push, input logic [31:0] res,
                       input bit chk_res, input logic we, input logic [4:0] dst,
                       output int stalls);
    exp_t e;
    @(posedge clk);
    #1;
    idex_bus = bus;
    if (push) begin
      e.res = res; e.chk_res = chk_res; e.we = we; e.dst = dst;
      exp_q.push_back(e);
    end
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 200) begin
      if (ex_we || ex_valid) bad_stall_cycles++;
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 200) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: still stalled after %0d cycles", stalls);
    end
  endtask

  task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic we,
                     input logic [3:0] ctl, input logic [4:0] dst, input logic cin,
                     input logic [31:0] res, input logic exp_we);
    int s;
    issue(mk(a, b, we, ctl, dst, cin, 3'b000), 1'b1, res, 1'b1, exp_we, dst, s);
  endtask

  task automatic md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                    output int stalls);
    issue(mk(a, b, 1'b1, 4'b0010, 5'd1, 1'b0, op), 1'b1, 32'd0, 1'b0, 1'b0, 5'd1, stalls);
  endtask

  task automatic mf(input bit hi, input logic [31:0] res, input logic [4:0] dst,
                    output int stalls);
    issue(mk(32'd0, 32'd0, 1'b1, 4'b0000, dst, 1'b0, hi ? 3'b101 : 3'b110), 1'b1, res, 1'b1,
          1'b1, dst, stalls);
  endtask

  task automatic bubble();
    @(posedge clk);
    #1;
    idex_bus = '0;
    @(negedge clk);
  endtask

  // Monitor: every valid output must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && ex_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: result %h dst %0d, nothing expected", ex_result,
                   ex_dst);
        end else begin
          e = exp_q.pop_front();
          if (e.chk_res) chk("ex_result", ex_result, e.res);
          chk("ex_we", {31'd0, ex_we}, {31'd0, e.we});
          chk("ex_dst", {27'd0, ex_dst}, {27'd0, e.dst});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    // Reset state
    #12;
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_we", {31'd0, ex_we}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ALU ops
    alu(32'd5, 32'd7, 1'b1, 4'b0010, 5'd3, 1'b1, 32'd13, 1'b1);
    alu(32'hFFFF_FFFF, 32'd1, 1'b1, 4'b0111, 5'd4, 1'b0, 32'd1, 1'b1);
    alu(32'd1, 32'hFFFF_FFFF, 1'b1, 4'b0111, 5'd4, 1'b0, 32'd0, 1'b1);
    alu(32'd5, 32'd7, 1'b1, 4'b0110, 5'd5, 1'b0, 32'hFFFF_FFFE, 1'b1);
    alu(32'hF0F0, 32'hFF00, 1'b0, 4'b0000, 5'd6, 1'b0, 32'hF000, 1'b0);
    alu(32'hF0F0, 32'hFF00, 1'b1, 4'b0001, 5'd7, 1'b0, 32'hFFF0, 1'b1);
    alu(32'hF0F0, 32'hFF00, 1'b1, 4'b0011, 5'd8, 1'b0, 32'h0FF0, 1'b1);
    alu(32'd0, 32'd0, 1'b1, 4'b1100, 5'd9, 1'b0, 32'hFFFF_FFFF, 1'b1);
    alu(32'hFFFF_FFFF, 32'd1, 1'b1, 4'b0010, 5'd10, 1'b0, 32'd0, 1'b1);
    alu(32'd9, 32'd9, 1'b1, 4'b0100, 5'd11, 1'b0, 32'd0, 1'b1);
    issue({14'd0, 1'b1, 3'b111, 1'b0, 5'd12, 4'b0001, 1'b1, 32'h30, 32'h0C}, 1'b1, 32'h3C,
          1'b1, 1'b1, 5'd12, s);
    bubble();

    // MULT / MULTU
    md(3'b001, 32'hFFFF_FFFF, 32'd2, s);
    mf(1'b1, 32'hFFFF_FFFF, 5'd13, s);
    mf(1'b0, 32'hFFFF_FFFE, 5'd14, s);
    md(3'b010, 32'hFFFF_FFFF, 32'd2, s);
    mf(1'b1, 32'd1, 5'd13, s);
    mf(1'b0, 32'hFFFF_FFFE, 5'd14, s);

    // DIV / DIVU incl. divide by zero and signed overflow
    md(3'b011, 32'hFFFF_FFF9, 32'd2, s);
    mf(1'b0, 32'hFFFF_FFFD, 5'd15, s);
    mf(1'b1, 32'hFFFF_FFFF, 5'd16, s);
    md(3'b100, 32'd7, 32'd0, s);
    mf(1'b0, 32'hFFFF_FFFF, 5'd15, s);
    mf(1'b1, 32'd7, 5'd16, s);
    md(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, s);
    mf(1'b0, 32'h8000_0000, 5'd15, s);
    mf(1'b1, 32'd0, 5'd16, s);
    md(3'b100, 32'd100, 32'd7, s);
    mf(1'b0, 32'd14, 5'd15, s);
    mf(1'b1, 32'd2, 5'd16, s);

    // MFLO right behind a MULT: stalls exactly MD_CYCLES cycles
    bubble();
    bad_stall_cycles = 0;
    md(3'b001, 32'd3, 32'hFFFF_FFFB, s);
    chk("mult_start_no_stall", s, 32'd0);
    mf(1'b0, 32'hFFFF_FFF1, 5'd9, s);
    chk("mflo_stall_cycles", s, 32'd32);
    chk("stall_outputs_quiet", bad_stall_cycles, 32'd0);
    chk("busy_after_done", {31'd0, md_busy}, 32'd0);

    // ALU op overlaps a busy unit; a second MULT waits for the first
    md(3'b010, 32'd6, 32'd7, s);
    bubble();
    bubble();
    bubble();
    alu(32'd20, 32'd22, 1'b1, 4'b0010, 5'd2, 1'b0, 32'd42, 1'b1);
    chk("busy_during_alu", {31'd0, md_busy}, 32'd1);
    md(3'b010, 32'd10, 32'd11, s);
    chk("second_mult_stall", s, 32'd28);
    mf(1'b0, 32'd110, 5'd3, s);
    chk("mflo_after_second", s, 32'd32);

    // Reset in the middle of a DIV
    md(3'b011, 32'd50, 32'd3, s);
    for (int i = 0; i < 9; i++) bubble();
    @(posedge clk);
    #3;
    idex_bus = '0;
    rst = 1'b0;
    #1;
    chk("rst_mid_div_busy", {31'd0, md_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mf(1'b1, 32'd0, 5'd20, s);
    chk("mfhi_after_rst_stall", s, 32'd0);
    mf(1'b0, 32'd0, 5'd21, s);

    bubble();
    bubble();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
